// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the tick counter.
// Nibble width, digit limit and load sanitising.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_sanitize(
    input logic [BCD_W-1:0] n
  );
    return (n > BCD_MAX) ? '0 : n;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain.
// Steps up/down; o_carry is the carry or borrow to the next digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_d,
  input  logic             i_step,
  input  logic             i_dir,
  output logic [BCD_W-1:0] o_q,
  output logic             o_carry
);
  logic [BCD_W-1:0] r_q;
  logic             w_at_end;

  assign w_at_end = i_dir ? (r_q == BCD_MAX) : (r_q == '0);
  assign o_carry  = i_step & w_at_end;
  assign o_q      = r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= bcd_sanitize(i_load_d);
    end else if (i_step) begin
      if (w_at_end)
        r_q <= i_dir ? '0 : BCD_MAX;
      else
        r_q <= i_dir ? r_q + 1'b1 : r_q - 1'b1;
    end
  end
endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled multi-digit BCD up/down counter.
// Serial snapshot readout on cs/dout, MSB first.
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int DIGITS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    snap_req,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    tick,
  output logic                    wrap,
  output logic                    cs,
  output logic                    dout,
  output logic                    busy
);
  localparam int CW = BCD_W * DIGITS;
  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = $clog2(CW);

  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic          r_wrap;
  logic [CW-1:0] r_shift;
  logic [SW-1:0] r_bit;
  logic          r_busy;
  logic          w_pre_end;
  logic          w_step;
  logic [DIGITS:0] w_carry;

  assign w_pre_end  = (r_pre == PW'(CLK_DIV - 1));
  assign w_step     = en & w_pre_end;
  assign w_carry[0] = w_step;

  // Carry/borrow ripples; the top digit's carry is the full wrap.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (clear),
      .i_load   (load),
      .i_load_d (load_val[g*BCD_W +: BCD_W]),
      .i_step   (w_carry[g]),
      .i_dir    (dir),
      .o_q      (count[g*BCD_W +: BCD_W]),
      .o_carry  (w_carry[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || clear || load) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_pre  <= w_pre_end ? '0 : r_pre + 1'b1;
      r_tick <= w_pre_end;
      r_wrap <= w_carry[DIGITS];
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_bit   <= '0;
    end else if (!r_busy) begin
      if (snap_req) begin
        r_shift <= count;
        r_busy  <= 1'b1;
        r_bit   <= '0;
      end
    end else begin
      r_shift <= {r_shift[CW-2:0], 1'b0};
      r_bit   <= r_bit + 1'b1;
      if (r_bit == SW'(CW - 1))
        r_busy <= 1'b0;
    end
  end

  assign tick = r_tick;
  assign wrap = r_wrap;
  assign busy = r_busy;
  assign cs   = ~r_busy;
  assign dout = r_busy & r_shift[CW-1];
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter (CLK_DIV=4, DIGITS=2).
// Expected counts and serial bits are queued, then popped on output.
module tb_bcd_tick_counter;
  localparam int CLK_DIV = 4;
  localparam int DIGITS  = 2;
  localparam int CW      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset, en, dir, clear, load, snap_req;
  logic [CW-1:0] load_val;
  logic [CW-1:0] count;
  logic          tick, wrap, cs, dout, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_pre, m_cnt;
  logic m_tick, m_wrap;
  logic [CW-1:0] cnt_q[$];
  logic          bit_q[$];
  logic [CW-1:0] exp_c;
  logic          exp_b;

  always #5 clk = ~clk;

  bcd_tick_counter #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir),
    .clear(clear), .load(load), .load_val(load_val),
    .snap_req(snap_req), .count(count), .tick(tick),
    .wrap(wrap), .cs(cs), .dout(dout), .busy(busy)
  );

  function automatic logic [7:0] to_bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Reference model of one enabled clock edge (decimal arithmetic).
  task automatic model_edge;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (m_pre == CLK_DIV - 1) begin
      m_pre  = 0;
      m_tick = 1'b1;
      m_wrap = dir ? (m_cnt == 99) : (m_cnt == 0);
      m_cnt  = dir ? (m_cnt + 1) % 100 : (m_cnt + 99) % 100;
      cnt_q.push_back(to_bcd(m_cnt));
    end else begin
      m_pre++;
    end
  endtask

  task automatic push_frame(input logic [CW-1:0] v);
    for (int i = CW - 1; i >= 0; i--) bit_q.push_back(v[i]);
  endtask

  task automatic do_load(input logic [CW-1:0] v, input int dec);
    load_val = v;
    load = 1'b1;
    cyc;
    load = 1'b0;
    m_cnt = dec;
    m_pre = 0;
    cnt_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; dir = 1'b1; clear = 1'b0;
    load = 1'b0; snap_req = 1'b0; load_val = '0;
    cyc; cyc;
    reset = 1'b0;
    n_checks++;
    if (count !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 ||
        cs !== 1'b1 || dout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%h tick=%b wrap=%b cs=%b dout=%b busy=%b, want 00 0 0 1 0 0",
               count, tick, wrap, cs, dout, busy);
    end
    m_pre = 0;
    m_cnt = 0;
    cnt_q.delete();
  endtask

  task automatic test_count_up;
    en = 1'b1; dir = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cyc;
      model_edge;
      n_checks++;
      if (tick !== m_tick || wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL up_tick c=%0d: tick=%b wrap=%b, want tick=%b wrap=%b",
                 c, tick, wrap, m_tick, m_wrap);
      end
      if (tick === 1'b1) begin
        n_checks++;
        if (cnt_q.size() == 0) begin
          n_fail++;
          $display("FAIL up_count c=%0d: unexpected tick, count=%h", c, count);
        end else begin
          exp_c = cnt_q.pop_front();
          if (count !== exp_c) begin
            n_fail++;
            $display("FAIL up_count c=%0d: count=%h, want %h", c, count, exp_c);
          end
        end
      end
    end
    en = 1'b0;
    n_checks++;
    if (count !== 8'h10 || cnt_q.size() != 0) begin
      n_fail++;
      $display("FAIL up_final: count=%h pending=%0d, want 10 pending=0",
               count, cnt_q.size());
    end
  endtask

  task automatic test_wrap_up;
    do_load(8'h99, 99);
    n_checks++;
    if (count !== 8'h99 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL load99: count=%h tick=%b, want 99 0", count, tick);
    end
    en = 1'b1; dir = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc;
      model_edge;
      n_checks++;
      if (tick !== m_tick || wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL wrap_up_tick c=%0d: tick=%b wrap=%b, want tick=%b wrap=%b",
                 c, tick, wrap, m_tick, m_wrap);
      end
      if (tick === 1'b1 && cnt_q.size() != 0) begin
        exp_c = cnt_q.pop_front();
        n_checks++;
        if (count !== exp_c) begin
          n_fail++;
          $display("FAIL wrap_up_count: count=%h, want %h", count, exp_c);
        end
      end
    end
    en = 1'b0;
    n_checks++;
    if (count !== 8'h00 || cnt_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_up_final: count=%h pending=%0d, want 00 0",
               count, cnt_q.size());
    end
  endtask

  task automatic test_down;
    logic [7:0] starts[2];
    int         decs[2];
    logic [7:0] ends[2];
    starts = '{8'h10, 8'h00};
    decs   = '{10, 0};
    ends   = '{8'h09, 8'h99};
    dir = 1'b0;
    for (int s = 0; s < 2; s++) begin
      do_load(starts[s], decs[s]);
      en = 1'b1;
      for (int c = 0; c < CLK_DIV; c++) begin
        cyc;
        model_edge;
        n_checks++;
        if (tick !== m_tick || wrap !== m_wrap) begin
          n_fail++;
          $display("FAIL down_tick s=%0d c=%0d: tick=%b wrap=%b, want tick=%b wrap=%b",
                   s, c, tick, wrap, m_tick, m_wrap);
        end
      end
      en = 1'b0;
      n_checks++;
      exp_c = (cnt_q.size() != 0) ? cnt_q.pop_front() : 8'hxx;
      if (count !== exp_c || count !== ends[s]) begin
        n_fail++;
        $display("FAIL down_count s=%0d: count=%h, want %h", s, count, ends[s]);
      end
    end
    dir = 1'b1;
  endtask

  task automatic test_load_clear;
    do_load(8'h3C, 30);
    n_checks++;
    if (count !== 8'h30) begin
      n_fail++;
      $display("FAIL load_sanitize: count=%h, want 30", count);
    end
    en = 1'b1; dir = 1'b1;
    cyc; cyc;
    clear = 1'b1; load = 1'b1; load_val = 8'h55;
    cyc;
    clear = 1'b0; load = 1'b0;
    m_pre = 0; m_cnt = 0;
    cnt_q.delete();
    n_checks++;
    if (count !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_over_load: count=%h tick=%b wrap=%b, want 00 0 0",
               count, tick, wrap);
    end
    for (int c = 0; c < CLK_DIV; c++) begin
      cyc;
      model_edge;
      n_checks++;
      if (tick !== m_tick) begin
        n_fail++;
        $display("FAIL clear_prescaler c=%0d: tick=%b, want %b", c, tick, m_tick);
      end
    end
    en = 1'b0;
    n_checks++;
    exp_c = (cnt_q.size() != 0) ? cnt_q.pop_front() : 8'hxx;
    if (count !== exp_c) begin
      n_fail++;
      $display("FAIL clear_next: count=%h, want %h", count, exp_c);
    end
  endtask

  task automatic test_readout;
    do_load(8'h42, 42);
    snap_req = 1'b1;
    en = 1'b1;
    push_frame(8'h42);
    cyc;
    snap_req = 1'b0;
    for (int k = 0; k < CW; k++) begin
      n_checks++;
      exp_b = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
      if (cs !== 1'b0 || busy !== 1'b1 || dout !== exp_b) begin
        n_fail++;
        $display("FAIL frame42 k=%0d: cs=%b busy=%b dout=%b, want 0 1 %b",
                 k, cs, busy, dout, exp_b);
      end
      snap_req = (k == 3);
      cyc;
    end
    snap_req = 1'b0;
    en = 1'b0;
    n_checks++;
    if (cs !== 1'b1 || busy !== 1'b0 || dout !== 1'b0 || count !== 8'h44) begin
      n_fail++;
      $display("FAIL frame42_end: cs=%b busy=%b dout=%b count=%h, want 1 0 0 44",
               cs, busy, dout, count);
    end
  endtask

  task automatic test_reset_mid_frame;
    snap_req = 1'b1;
    push_frame(count);
    cyc;
    snap_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      exp_b = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
      if (cs !== 1'b0 || dout !== exp_b) begin
        n_fail++;
        $display("FAIL frame_pre_reset k=%0d: cs=%b dout=%b, want 0 %b",
                 k, cs, dout, exp_b);
      end
      cyc;
    end
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    bit_q.delete();
    n_checks++;
    if (cs !== 1'b1 || busy !== 1'b0 || dout !== 1'b0 || count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_frame: cs=%b busy=%b dout=%b count=%h, want 1 0 0 00",
               cs, busy, dout, count);
    end
  endtask

  task automatic test_back_to_back;
    do_load(8'h27, 27);
    for (int f = 0; f < 2; f++) begin
      snap_req = 1'b1;
      push_frame(8'h27);
      if (f == 1) begin
        load = 1'b1;
        load_val = 8'h81;
      end
      cyc;
      snap_req = 1'b0;
      load = 1'b0;
      for (int k = 0; k < CW; k++) begin
        n_checks++;
        exp_b = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
        if (cs !== 1'b0 || busy !== 1'b1 || dout !== exp_b) begin
          n_fail++;
          $display("FAIL frame27 f=%0d k=%0d: cs=%b busy=%b dout=%b, want 0 1 %b",
                   f, k, cs, busy, dout, exp_b);
        end
        cyc;
      end
      n_checks++;
      if (cs !== 1'b1 || busy !== 1'b0 || dout !== 1'b0) begin
        n_fail++;
        $display("FAIL frame27_end f=%0d: cs=%b busy=%b dout=%b, want 1 0 0",
                 f, cs, busy, dout);
      end
    end
    n_checks++;
    if (count !== 8'h81) begin
      n_fail++;
      $display("FAIL load_during_frame: count=%h, want 81", count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_count_up;
    test_wrap_up;
    test_down;
    test_load_clear;
    test_readout;
    test_reset_mid_frame;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
